udm_uart_rx: RTL and testbench
==============================

Name: udm_uart_rx

Overview:
- UART receive front end of the UDM debug bridge. Deserializes the host's serial stream on the UART_TXD_IN pin into bytes for the UDM command decoder.
- Baud rate and frame format are runtime-configurable, so the same bitstream serves 115200/19200/9600/4800/2400 hosts.
- Sits between the board pin and the UDM byte-level protocol parser.
- Reports parity and framing errors so the parser can drop corrupted commands.

Parameters:
- DIV_WIDTH, 32, width of the bit-period divider input.
- MIN_DIV, 4, smallest accepted divider; smaller values are clamped to this.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous and active-high
- rx_i  input  1  serial line from the pin, asynchronous to clk_i; idle high
- divider_i  input  DIV_WIDTH  clk_i cycles per bit
- cfg_i  input  2  frame format: 00 = 8N1, 01 = 8E1, 10 = 8O1, 11 = treated as 8N1
- rx_done_o  output  1  one-cycle pulse: a byte was received with a valid stop bit
- rx_data_o  output  8  received byte; held until the next rx_done_o
- perr_o  output  1  one-cycle pulse coincident with rx_done_o when the parity bit mismatched
- ferr_o  output  1  one-cycle pulse when the stop bit sampled 0
- busy_o  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchronizer flops preset to 1 (line idle).
- rx_i passes through a 2-FF synchronizer before any use.
- divider_i and cfg_i are latched when a start bit is detected; changes mid-frame have no effect on that frame.
- Effective divider D = max(divider_i, MIN_DIV). Half period H = D >> 1.
- FSM states:
  - IDLE: on a synchronized 1->0 transition, load counter with H-1, latch cfg, go to START.
  - START: on counter expiry, sample the line. If 0, load D-1 and go to DATA. If 1 (glitch), return to IDLE with no outputs.
  - DATA: sample on each expiry (counter reloaded with D-1), LSB first, into a shift register. After bit 7, go to PARITY if cfg is 01/10, else STOP.
  - PARITY: sample one bit. Even: expected = XOR of data. Odd: expected = ~XOR of data. Store the mismatch flag; go to STOP.
  - STOP: sample.
    - If 1: rx_data_o <= shift register; rx_done_o = 1 for one cycle; perr_o = stored mismatch in the same cycle; go to IDLE.
    - If 0: ferr_o = 1 for one cycle; rx_data_o unchanged; no rx_done_o; go to BREAK.
  - BREAK: wait for synchronized line = 1, then IDLE. A held-low line (break) produces exactly one ferr_o.
- Latency: rx_done_o rises at the stop-bit sample point (start edge + 2 sync cycles + H + 9·D for 8N1, + 10·D with parity) + 1 cycle.
- Back-to-back frames: a start edge is accepted in the first IDLE cycle after STOP. Half-stop-bit slack permits ±~4% baud mismatch.
- Reset asserted mid-frame: immediate return to IDLE, outputs cleared, partial byte discarded. No pulse is emitted after reset release unless a new start bit arrives.
- Counter is DIV_WIDTH wide; no wrap-around is possible because it only counts down from D-1.

Optional Feature:
- Macro UDM_UART_RX_MAJORITY_EN.
- Defined: each sample point takes three synchronized samples at counter values 1, 0 and the following cycle. The bit value is the 2-of-3 majority, and the decision is applied one cycle later.
  - rx_done_o / ferr_o timing shifts by +1 cycle.
  - Start-glitch rejection uses the same vote.
- Undefined: single sample at counter expiry, as above.

Test Plan:
- Divider 868, cfg 00, send 0x55 then 0xA3 back-to-back with one stop bit each -> two rx_done_o pulses; rx_data_o = 0x55 then 0xA3; perr_o = ferr_o = 0.
- Divider 868, cfg 01, send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first frame perr_o = 0; second frame perr_o = 1 coincident with rx_done_o; rx_data_o = 0x07 both times.
- Divider 868, cfg 10, send 0x00 with stop bit 0, then hold rx low 30·D, then release and send 0x5A -> exactly one ferr_o; no rx_done_o for the bad frame; then rx_data_o = 0x5A with rx_done_o.
- Divider 868, pulse rx_i low for 200 cycles -> no rx_done_o, no ferr_o, busy_o returns to 0.
- Divider 868, start 0xC3; assert rst_i during data bit 4 for 10 cycles; send 0x3C -> all outputs 0 during reset; only 0x3C reported, one rx_done_o.
- divider_i = 2 (clamped to 4), send 0x81 -> rx_data_o = 0x81. Also change divider_i from 868 to 434 mid-frame -> current frame still decoded at 868 correctly.

Source files
------------

// File: rtl/udm_uart_rx_if.sv
// Signal bundle between the UDM UART receiver and its surroundings.
// The master side drives the serial line and configuration; the slave side returns bytes and status.
interface udm_uart_rx_if #(
    parameter int DIV_WIDTH = 32
);
    logic                 rx_i;
    logic [DIV_WIDTH-1:0] divider_i;
    logic [1:0]           cfg_i;
    logic                 rx_done_o;
    logic [7:0]           rx_data_o;
    logic                 perr_o;
    logic                 ferr_o;
    logic                 busy_o;

    modport master (
        output rx_i, divider_i, cfg_i,
        input  rx_done_o, rx_data_o, perr_o, ferr_o, busy_o
    );

    modport slave (
        input  rx_i, divider_i, cfg_i,
        output rx_done_o, rx_data_o, perr_o, ferr_o, busy_o
    );
endinterface

// File: rtl/udm_uart_rx.sv
// UART receive front end of the UDM debug bridge: 8N1/8E1/8O1 with runtime bit-period divider.
// Optional macro UDM_UART_RX_MAJORITY_EN enables a 2-of-3 vote around every sample point.
module udm_uart_rx #(
    parameter int DIV_WIDTH = 32,
    parameter int MIN_DIV   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    udm_uart_rx_if.slave bus
);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a synchronized falling edge
    // S_START  | half a bit in, confirming the start bit
    // S_DATA   | sampling 8 data bits, LSB first
    // S_PARITY | sampling the parity bit (8E1/8O1 only)
    // S_STOP   | sampling the stop bit
    // S_BREAK  | framing error seen, waiting for the line to return high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    localparam logic [DIV_WIDTH-1:0] MIN_D = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [DIV_WIDTH-1:0] cnt, d_lat, d_new, h_new;
    logic [1:0]           cfg_lat;
    logic [7:0]           shreg;
    logic [2:0]           bit_idx;
    logic                 par_err;
    logic                 fall, active, tick, decide, bit_val, parity_en;
    logic                 start_load, shift_en, par_en, done_set, ferr_set, busy;
    logic                 rx_done_r, perr_r, ferr_r;
    logic [7:0]           rx_data_r;

    assign d_new     = (bus.divider_i < MIN_D) ? MIN_D : bus.divider_i;
    assign h_new     = d_new >> 1;
    assign fall      = rx_prev & ~rx_sync;
    assign active    = (state == S_START) || (state == S_DATA) ||
                       (state == S_PARITY) || (state == S_STOP);
    assign tick      = active && (cnt == '0);
    assign parity_en = cfg_lat[0] ^ cfg_lat[1];

`ifdef UDM_UART_RX_MAJORITY_EN
    logic s_early, s_mid, pend;

    // The counter reloads on expiry as usual; only the decision lags by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
            pend    <= 1'b0;
        end else begin
            pend <= tick;
            if (active && (cnt == ONE))
                s_early <= rx_sync;
            if (tick)
                s_mid <= rx_sync;
        end
    end

    assign decide  = pend;
    assign bit_val = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);
`else
    assign decide  = tick;
    assign bit_val = rx_sync;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fall) state_nxt = S_START;
            S_START:  if (decide) state_nxt = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (decide && (bit_idx == 3'd7))
                          state_nxt = parity_en ? S_PARITY : S_STOP;
            S_PARITY: if (decide) state_nxt = S_STOP;
            S_STOP:   if (decide) state_nxt = bit_val ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_sync) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_load = (state == S_IDLE) && fall;
        shift_en   = (state == S_DATA) && decide;
        par_en     = (state == S_PARITY) && decide;
        done_set   = (state == S_STOP) && decide && bit_val;
        ferr_set   = (state == S_STOP) && decide && !bit_val;
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            d_lat     <= MIN_D;
            cfg_lat   <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            par_err   <= 1'b0;
            rx_data_r <= '0;
            rx_done_r <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            rx_meta   <= bus.rx_i;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            rx_done_r <= done_set;
            perr_r    <= done_set & par_err;
            ferr_r    <= ferr_set;

            // Divider and format are frozen for the whole frame at start detection.
            if (start_load) begin
                cnt     <= h_new - ONE;
                d_lat   <= d_new;
                cfg_lat <= bus.cfg_i;
                bit_idx <= '0;
                par_err <= 1'b0;
            end else if (tick) begin
                cnt <= d_lat - ONE;
            end else if (active) begin
                cnt <= cnt - ONE;
            end

            if (shift_en) begin
                shreg   <= {bit_val, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (par_en)
                par_err <= bit_val ^ (^shreg) ^ cfg_lat[1];

            if (done_set)
                rx_data_r <= shreg;
        end
    end

    assign bus.rx_done_o = rx_done_r;
    assign bus.rx_data_o = rx_data_r;
    assign bus.perr_o    = perr_r;
    assign bus.ferr_o    = ferr_r;
    assign bus.busy_o    = busy;

endmodule

// File: tb/tb_udm_uart_rx.sv
// Directed bench for udm_uart_rx: frame formats, parity/framing errors, glitch, reset, divider clamp.
module tb_udm_uart_rx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    udm_uart_rx_if #(.DIV_WIDTH(32)) bus();

    udm_uart_rx #(.DIV_WIDTH(32), .MIN_DIV(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

`ifdef UDM_UART_RX_MAJORITY_EN
    localparam int VOTE_LAT = 1;
`else
    localparam int VOTE_LAT = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int         cyc = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    logic [7:0] hist [64];
    logic       phist[64];
    int         dcyc [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_done_o && done_cnt < 64) begin
            hist[done_cnt]  <= bus.rx_data_o;
            phist[done_cnt] <= bus.perr_o;
            dcyc[done_cnt]  <= cyc;
            done_cnt        <= done_cnt + 1;
        end
        if (bus.ferr_o) ferr_cnt <= ferr_cnt + 1;
        if (bus.perr_o) perr_cnt <= perr_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling clock edge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] data, input int d, input bit has_par,
                              input logic par_bit, input logic stop_bit);
        bus.rx_i = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = data[i];
            repeat (d) @(negedge clk);
        end
        if (has_par) begin
            bus.rx_i = par_bit;
            repeat (d) @(negedge clk);
        end
        bus.rx_i = stop_bit;
        repeat (d) @(negedge clk);
    endtask

    int b, fb, t0;
    logic [7:0] c3;

    initial begin
        rst           = 1'b1;
        bus.rx_i      = 1'b1;
        bus.divider_i = 32'd868;
        bus.cfg_i     = 2'b00;
        repeat (3) @(negedge clk);
        check_val("reset_done",  {31'd0, bus.rx_done_o}, 32'd0);
        check_val("reset_data",  {24'd0, bus.rx_data_o}, 32'd0);
        check_val("reset_perr",  {31'd0, bus.perr_o},    32'd0);
        check_val("reset_ferr",  {31'd0, bus.ferr_o},    32'd0);
        check_val("reset_busy",  {31'd0, bus.busy_o},    32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 back-to-back at 868; first frame also checks the done latency H+3+9D.
        b  = done_cnt;
        t0 = cyc;
        send_frame(8'h55, 868, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA3, 868, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_val("b2b_count", done_cnt, b + 2);
        check_val("b2b_data0", {24'd0, hist[b]},     32'h55);
        check_val("b2b_data1", {24'd0, hist[b + 1]}, 32'hA3);
        check_val("b2b_latency", dcyc[b] - t0, 434 + 3 + 9 * 868 + VOTE_LAT);
        check_val("b2b_perr", perr_cnt, 0);
        check_val("b2b_ferr", ferr_cnt, 0);

        // 8E1: 0x07 has three ones, so the correct even parity bit is 1.
        bus.divider_i = 32'd217;
        bus.cfg_i     = 2'b01;
        b = done_cnt;
        send_frame(8'h07, 217, 1'b1, 1'b1, 1'b1);
        send_frame(8'h07, 217, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_val("even_count", done_cnt, b + 2);
        check_val("even_data0", {24'd0, hist[b]},     32'h07);
        check_val("even_data1", {24'd0, hist[b + 1]}, 32'h07);
        check_val("even_perr0", {31'd0, phist[b]},     32'd0);
        check_val("even_perr1", {31'd0, phist[b + 1]}, 32'd1);
        check_val("even_perr_total", perr_cnt, 1);

        // 8O1: bad stop bit followed by a long break, then a good 0x5A (four ones -> parity 1).
        bus.cfg_i = 2'b10;
        b  = done_cnt;
        fb = ferr_cnt;
        send_frame(8'h00, 217, 1'b1, 1'b1, 1'b0);
        repeat (30 * 217) @(negedge clk);
        bus.rx_i = 1'b1;
        repeat (2 * 217) @(negedge clk);
        check_val("break_ferr", ferr_cnt, fb + 1);
        check_val("break_nodone", done_cnt, b);
        check_val("break_data_held", {24'd0, bus.rx_data_o}, 32'h07);
        check_val("break_busy", {31'd0, bus.busy_o}, 32'd0);
        send_frame(8'h5A, 217, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check_val("odd_count", done_cnt, b + 1);
        check_val("odd_data", {24'd0, hist[b]}, 32'h5A);
        check_val("odd_perr", {31'd0, phist[b]}, 32'd0);
        check_val("odd_ferr", ferr_cnt, fb + 1);

        // 200-cycle low pulse at 868 is shorter than half a bit: rejected as a glitch.
        bus.divider_i = 32'd868;
        bus.cfg_i     = 2'b00;
        b  = done_cnt;
        fb = ferr_cnt;
        bus.rx_i = 1'b0;
        repeat (100) @(negedge clk);
        check_val("glitch_busy_hi", {31'd0, bus.busy_o}, 32'd1);
        repeat (100) @(negedge clk);
        bus.rx_i = 1'b1;
        repeat (868) @(negedge clk);
        check_val("glitch_busy_lo", {31'd0, bus.busy_o}, 32'd0);
        check_val("glitch_nodone", done_cnt, b);
        check_val("glitch_noferr", ferr_cnt, fb);

        // Reset in the middle of data bit 4 of 0xC3; the host abandons that frame.
        bus.divider_i = 32'd217;
        b  = done_cnt;
        fb = ferr_cnt;
        c3 = 8'hC3;
        bus.rx_i = 1'b0;
        repeat (217) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx_i = c3[i];
            repeat (217) @(negedge clk);
        end
        bus.rx_i = c3[4];
        repeat (108) @(negedge clk);
        check_val("rst_busy_before", {31'd0, bus.busy_o}, 32'd1);
        rst      = 1'b1;
        bus.rx_i = 1'b1;
        @(negedge clk);
        check_val("rst_mid_done", {31'd0, bus.rx_done_o}, 32'd0);
        check_val("rst_mid_data", {24'd0, bus.rx_data_o}, 32'd0);
        check_val("rst_mid_perr", {31'd0, bus.perr_o},    32'd0);
        check_val("rst_mid_ferr", {31'd0, bus.ferr_o},    32'd0);
        check_val("rst_mid_busy", {31'd0, bus.busy_o},    32'd0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        repeat (3 * 217) @(negedge clk);
        check_val("rst_after_nodone", done_cnt, b);
        check_val("rst_after_noferr", ferr_cnt, fb);
        send_frame(8'h3C, 217, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_val("rst_new_count", done_cnt, b + 1);
        check_val("rst_new_data", {24'd0, hist[b]}, 32'h3C);

        // Divider 2 is clamped to 4, so the host must send 4-cycle bits.
        bus.divider_i = 32'd2;
        b = done_cnt;
        send_frame(8'h81, 4, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_val("clamp_count", done_cnt, b + 1);
        check_val("clamp_data", {24'd0, hist[b]}, 32'h81);

        // Divider changed to 434 during data bit 3; the frame in flight stays at 868.
        bus.divider_i = 32'd868;
        repeat (10) @(negedge clk);
        b  = done_cnt;
        fb = ferr_cnt;
        fork
            send_frame(8'hB6, 868, 1'b0, 1'b0, 1'b1);
            begin
                repeat (868 * 4 + 400) @(negedge clk);
                bus.divider_i = 32'd434;
            end
        join
        repeat (20) @(negedge clk);
        check_val("divchg_count", done_cnt, b + 1);
        check_val("divchg_data", {24'd0, hist[b]}, 32'hB6);
        check_val("divchg_ferr", ferr_cnt, fb);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
